work_uart_host: RTL

//  Host/cluster-side end of the miner serial link. Serialises one work unit (256b midstate + 256b data2)
//  as 64 UART 8N1 bytes onto the line feeding a miner's RxD, and deserialises 4-byte golden nonces

---
 rtl/miner_uart_pkg.sv | 21 ++
 rtl/uart_rx_byte.sv | 99 +++++++++
 rtl/work_uart_host.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/miner_uart_pkg.sv
// Shared constants for the miner serial link: frame sizes, FSM state codes and the bit-period helper.
package miner_uart_pkg;

    localparam int unsigned WORK_BYTES  = 64;
    localparam int unsigned NONCE_BYTES = 4;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, falling-edge start detect with mid-start glitch rejection,
// centre sampling of data and stop bits. Emits one-cycle byte_valid or frame_err pulses.
module uart_rx_byte
    import miner_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       hash_clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] rx_data,
    output logic       frame_err,
    output logic [1:0] state_dbg
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    assign state_dbg = state;

    // Synchroniser resets to the idle-line level so reset release never looks like a start bit.
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_data    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rx_sync) state <= RX_START;
                end
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[7:1]};
                        if (bit_idx == 3'd7) state <= RX_STOP;
                        else                 bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // Stop bit judged at its centre; the second half is not waited for.
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            rx_data    <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/work_uart_host.sv
// Host end of the miner serial link: streams a 64-byte work unit out on TxD and assembles 4-byte nonces
// from RxD. Optional macro NONCE_RX_TIMEOUT_EN drops a partial nonce after a long inter-byte gap.
module work_uart_host
    import miner_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned BAUD         = 115_200,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic         hash_clk,
    input  logic         reset_n,
    input  logic         work_valid,
    output logic         work_ready,
    input  logic [255:0] midstate,
    input  logic [255:0] data2,
    output logic         TxD,
    input  logic         RxD,
    output logic         nonce_valid,
    output logic [31:0]  nonce,
    output logic         frame_err,
    output logic [1:0]   tx_state_dbg,
    output logic [1:0]   rx_state_dbg
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    // work_valid/work_ready: a unit transfers on a cycle where both are high; midstate/data2 need only
    // be stable on that cycle. work_valid while work_ready is low is ignored, not held pending.
    logic [1:0]       tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [5:0]       tx_byte;
    logic [511:0]     tx_shreg;
    logic             txd_q;
    logic             bit_end;

    assign work_ready   = (tx_state == TX_IDLE);
    assign TxD          = txd_q;
    assign tx_state_dbg = tx_state;
    assign bit_end      = (tx_cnt == CNT_MAX);

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_byte  <= '0;
            tx_shreg <= '0;
            txd_q    <= 1'b1;
        end else begin
            if (tx_state != TX_IDLE) tx_cnt <= bit_end ? '0 : tx_cnt + 1'b1;
            case (tx_state)
                TX_IDLE: begin
                    if (work_valid && work_ready) begin
                        tx_shreg <= {data2, midstate};
                        tx_byte  <= '0;
                        tx_cnt   <= '0;
                        txd_q    <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        txd_q    <= tx_shreg[0];
                        tx_shreg <= {1'b0, tx_shreg[511:1]};
                        tx_bit   <= '0;
                        tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        if (tx_bit == 3'd7) begin
                            txd_q    <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            txd_q    <= tx_shreg[0];
                            tx_shreg <= {1'b0, tx_shreg[511:1]};
                            tx_bit   <= tx_bit + 1'b1;
                        end
                    end
                end
                default: begin
                    // Next start bit follows the stop bit directly: no inter-byte idle.
                    if (bit_end) begin
                        if (tx_byte == 6'(WORK_BYTES - 1)) begin
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_byte  <= tx_byte + 1'b1;
                            txd_q    <= 1'b0;
                            tx_state <= TX_START;
                        end
                    end
                end
            endcase
        end
    end

    logic       rx_byte_valid;
    logic [7:0] rx_data;
    logic       rx_frame_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .hash_clk  (hash_clk),
        .reset_n   (reset_n),
        .rx        (RxD),
        .byte_valid(rx_byte_valid),
        .rx_data   (rx_data),
        .frame_err (rx_frame_err),
        .state_dbg (rx_state_dbg)
    );

    assign frame_err = rx_frame_err;

    logic [1:0]  byte_cnt;
    logic [23:0] partial;

`ifdef NONCE_RX_TIMEOUT_EN
    localparam int unsigned GAP_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned GAP_W      = $clog2(GAP_CYCLES + 1);

    logic [GAP_W-1:0] gap_cnt;
    logic             gap_expired;

    assign gap_expired = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt <= '0;
        end else if (rx_state_dbg != RX_IDLE || byte_cnt == 2'd0) begin
            gap_cnt <= '0;
        end else if (!gap_expired) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt    <= '0;
            partial     <= '0;
            nonce       <= '0;
            nonce_valid <= 1'b0;
        end else begin
            nonce_valid <= 1'b0;
            if (rx_frame_err) begin
                byte_cnt <= '0;
            end else if (rx_byte_valid) begin
                if (byte_cnt == 2'(NONCE_BYTES - 1)) begin
                    nonce       <= {rx_data, partial};
                    nonce_valid <= 1'b1;
                    byte_cnt    <= '0;
                end else begin
                    partial[byte_cnt*8 +: 8] <= rx_data;
                    byte_cnt                 <= byte_cnt + 1'b1;
                end
`ifdef NONCE_RX_TIMEOUT_EN
            end else if (gap_expired) begin
                byte_cnt <= '0;
`endif
            end
        end
    end

endmodule
